// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between instruction fetch and the
// MEM stage. Multi-byte accesses become consecutive little-endian byte cycles.
// MEM has priority at grant time; an in-flight IF read is never preempted.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_rdy,
    output logic [31:0]       if_data,
    input  logic [4:0]        mem_e,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_rdy,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;        // cycles elapsed since grant, minus one
    logic [2:0]        nbytes, nbytes_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [31:0]       wdata, wdata_n;
    logic              sext, sext_n;
    logic [31:0]       rbuf, rbuf_n;      // read bytes assembled so far
    logic [ADDR_W-1:0] ram_a_n;
    logic              ram_wr_n, if_rdy_n, mem_rdy_n, busy_n;
    logic [7:0]        ram_dout_n;
    logic [31:0]       if_data_n, mem_rdata_n;
    logic [1:0]        rd_idx, wr_idx;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n,
                                           input logic sx);
        case (n)
            3'd1:    extend = {{24{sx & w[7]}}, w[7:0]};
            3'd2:    extend = {{16{sx & w[15]}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    // Register every output together with the FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            nbytes    <= '0;
            addr      <= '0;
            wdata     <= '0;
            sext      <= 1'b0;
            rbuf      <= '0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
            if_rdy    <= 1'b0;
            mem_rdy   <= 1'b0;
            if_data   <= '0;
            mem_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            nbytes    <= nbytes_n;
            addr      <= addr_n;
            wdata     <= wdata_n;
            sext      <= sext_n;
            rbuf      <= rbuf_n;
            ram_a     <= ram_a_n;
            ram_wr    <= ram_wr_n;
            ram_dout  <= ram_dout_n;
            if_rdy    <= if_rdy_n;
            mem_rdy   <= mem_rdy_n;
            if_data   <= if_data_n;
            mem_rdata <= mem_rdata_n;
            busy      <= busy_n;
        end
    end

    // Next state and next registered outputs; ram_a and data outputs hold by default.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        nbytes_n    = nbytes;
        addr_n      = addr;
        wdata_n     = wdata;
        sext_n      = sext;
        rbuf_n      = rbuf;
        ram_a_n     = ram_a;
        ram_wr_n    = 1'b0;
        ram_dout_n  = ram_dout;
        if_rdy_n    = 1'b0;
        mem_rdy_n   = 1'b0;
        if_data_n   = if_data;
        mem_rdata_n = mem_rdata;
        rd_idx      = 2'(cnt - 3'd1);
        wr_idx      = 2'(cnt + 3'd1);

        case (state)
            IDLE: begin
                if (mem_e[4]) begin
                    addr_n   = mem_addr;
                    wdata_n  = mem_wdata;
                    sext_n   = mem_e[0];
                    nbytes_n = (mem_e[3:2] == 2'd0) ? 3'd1 :
                               (mem_e[3:2] == 2'd1) ? 3'd2 : 3'd4;
                    cnt_n    = '0;
                    rbuf_n   = '0;
                    ram_a_n  = mem_addr;
                    if (mem_e[1]) begin
                        state_n    = MEM_WR;
                        ram_wr_n   = 1'b1;
                        ram_dout_n = mem_wdata[7:0];
                    end else begin
                        state_n = MEM_RD;
                    end
                end else if (if_req && !if_flush) begin
                    addr_n   = if_addr;
                    sext_n   = 1'b0;
                    nbytes_n = 3'd4;
                    cnt_n    = '0;
                    rbuf_n   = '0;
                    ram_a_n  = if_addr;
                    state_n  = IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                if (state == IF_RD && if_flush) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 3'd1;
                    if (cnt + 3'd1 < nbytes)
                        ram_a_n = addr + ADDR_W'(cnt + 3'd1);
                    // ram_din carries the byte addressed one cycle earlier
                    if (cnt != 3'd0)
                        rbuf_n[{rd_idx, 3'b000} +: 8] = ram_din;
                    if (cnt == nbytes) begin
                        state_n = DONE;
                        if (state == IF_RD) begin
                            if_rdy_n  = 1'b1;
                            if_data_n = rbuf_n;
                        end else begin
                            mem_rdy_n   = 1'b1;
                            mem_rdata_n = extend(rbuf_n, nbytes, sext);
                        end
                    end
                end
            end
            MEM_WR: begin
                cnt_n = cnt + 3'd1;
                if (cnt + 3'd1 < nbytes) begin
                    ram_a_n    = addr + ADDR_W'(cnt + 3'd1);
                    ram_wr_n   = 1'b1;
                    ram_dout_n = wdata[{wr_idx, 3'b000} +: 8];
                end else begin
                    state_n     = DONE;
                    mem_rdy_n   = 1'b1;
                    mem_rdata_n = '0;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 256-byte RAM model (aliased on ram_a[7:0]) answers
// the DUT; a separate shadow memory plus per-access arithmetic gives expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_rdy;
    logic [31:0] if_data;
    logic [4:0]  mem_e = '0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic        mem_rdy;
    logic [31:0] mem_rdata;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = '0;
    logic        busy;

    logic [7:0]  ram [256];
    logic [7:0]  ref_mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_a = '0, bd_d = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdy(if_rdy), .if_data(if_data),
        .mem_e(mem_e), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .busy(busy)
    );

    // RAM: read data valid the cycle after the address; writes and backdoor loads at the edge.
    always @(posedge clk) begin
        ram_din <= ram[ram_a[7:0]];
        if (ram_wr) ram[ram_a[7:0]] <= ram_dout;
        if (bd_we)  ram[bd_a] <= bd_d;
    end

    // One complete access; the bench computes all expectations from the shadow memory.
    task automatic do_access(input bit is_if, input logic [31:0] a, input logic [1:0] len,
                             input bit wr, input bit sx, input logic [31:0] wd,
                             input bit keep_if, input logic [31:0] if_a2);
        int n, rk;
        longint v;
        logic [31:0] exp, got;
        logic gr, orr;
        n  = is_if ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
        rk = (wr && !is_if) ? n + 1 : n + 2;
        v  = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[8'(a + 32'(i))]) << (8 * i);
        if (!is_if && sx && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        exp = (wr && !is_if) ? 32'd0 : 32'(v);
        if (is_if) begin if_req = 1'b1; if_addr = a; end
        else begin mem_e = {1'b1, len, wr, sx}; mem_addr = a; mem_wdata = wd; end
        if (keep_if) begin if_req = 1'b1; if_addr = if_a2; end
        for (int k = 1; k <= rk + 1; k++) begin
            @(posedge clk); #1;
            if (k <= n) begin
                total++; if (ram_a !== a + 32'(k - 1)) begin bad++; $display("FAIL ram_a k=%0d got=%h exp=%h", k, ram_a, a + 32'(k - 1)); end
                total++; if (ram_wr !== (wr && !is_if)) begin bad++; $display("FAIL ram_wr k=%0d got=%b exp=%b", k, ram_wr, wr && !is_if); end
                if (wr && !is_if) begin
                    total++; if (ram_dout !== 8'(wd >> (8 * (k - 1)))) begin bad++; $display("FAIL ram_dout k=%0d got=%h exp=%h", k, ram_dout, 8'(wd >> (8 * (k - 1)))); end
                end
            end else begin
                total++; if (ram_wr !== 1'b0) begin bad++; $display("FAIL ram_wr_idle k=%0d got=%b exp=0", k, ram_wr); end
            end
            gr  = is_if ? if_rdy : mem_rdy;
            orr = is_if ? mem_rdy : if_rdy;
            got = is_if ? if_data : mem_rdata;
            total++; if (gr !== (k == rk)) begin bad++; $display("FAIL rdy k=%0d got=%b exp=%b", k, gr, k == rk); end
            total++; if (orr !== 1'b0) begin bad++; $display("FAIL other_rdy k=%0d got=%b exp=0", k, orr); end
            total++; if (busy !== (k <= rk)) begin bad++; $display("FAIL busy k=%0d got=%b exp=%b", k, busy, k <= rk); end
            if (k >= rk) begin
                total++; if (got !== exp) begin bad++; $display("FAIL data k=%0d a=%h got=%h exp=%h", k, a, got, exp); end
            end
            if (k == rk) begin
                if (is_if) if_req = 1'b0; else mem_e = '0;
                if (wr && !is_if)
                    for (int i = 0; i < n; i++) ref_mem[8'(a + 32'(i))] = 8'(wd >> (8 * i));
            end
        end
        if (is_if) if_req = 1'b0; else mem_e = '0;
    endtask

    task automatic test_reset;
        total++; if ({if_rdy, mem_rdy, ram_wr, busy} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {if_rdy, mem_rdy, ram_wr, busy}); end
        total++; if ({if_data, mem_rdata, ram_a, ram_dout} !== 104'd0) begin bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", if_data, mem_rdata, ram_a, ram_dout); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_if_fetch;
        do_access(1'b1, 32'h100, 2'd3, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        total++; if (if_data !== 32'h00100513) begin bad++; $display("FAIL if_word got=%h exp=00100513", if_data); end
    endtask

    task automatic test_loads;
        do_access(1'b0, 32'h20, 2'd0, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0);
        total++; if (mem_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h exp=FFFFFF80", mem_rdata); end
        do_access(1'b0, 32'h30, 2'd1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        total++; if (mem_rdata !== 32'h0000BEEF) begin bad++; $display("FAIL lhu got=%h exp=0000BEEF", mem_rdata); end
    endtask

    task automatic test_store;
        do_access(1'b0, 32'h40, 2'd3, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'd0);
        do_access(1'b0, 32'h40, 2'd3, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        total++; if (mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_readback got=%h exp=DEADBEEF", mem_rdata); end
    endtask

    task automatic test_arbitration;
        // both request in the same idle cycle; IF stays pending through MEM's DONE
        do_access(1'b0, 32'h40, 2'd3, 1'b0, 1'b0, 32'd0, 1'b1, 32'h100);
        do_access(1'b1, 32'h100, 2'd3, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic test_flush;
        if_req = 1'b1; if_addr = 32'h104;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (ram_a !== 32'h105) begin bad++; $display("FAIL flush_c2 ram_a got=%h exp=105", ram_a); end
        if_flush = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_abort busy got=%b exp=0", busy); end
        // flush held in IDLE blocks the grant
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_block busy got=%b exp=0", busy); end
        end
        if_req = 1'b0; if_flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (if_rdy !== 1'b0 || ram_a !== 32'h105) begin bad++; $display("FAIL flush_quiet rdy=%b ram_a=%h exp=0/105", if_rdy, ram_a); end
        end
        // flush does not disturb a MEM access
        if_flush = 1'b1;
        do_access(1'b0, 32'h100, 2'd3, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        if_flush = 1'b0;
    endtask

    task automatic test_reset_mid;
        mem_e = 5'b1_11_1_0; mem_addr = 32'h60; mem_wdata = 32'h11223344;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (ram_wr !== 1'b1) begin bad++; $display("FAIL rstmid_c2 ram_wr got=%b exp=1", ram_wr); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if ({ram_wr, busy, mem_rdy} !== 3'b0) begin bad++; $display("FAIL rstmid wr/busy/rdy got=%b exp=000", {ram_wr, busy, mem_rdy}); end
        rst = 1'b0; mem_e = '0;
        ref_mem[8'h60] = 8'h44; ref_mem[8'h61] = 8'h33;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if ({ram_wr, busy, mem_rdy} !== 3'b0) begin bad++; $display("FAIL rstmid_after got=%b exp=000", {ram_wr, busy, mem_rdy}); end
        end
        do_access(1'b0, 32'h60, 2'd3, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic test_wrap;
        do_access(1'b0, 32'hFFFFFFFF, 2'd0, 1'b1, 1'b0, 32'h5A, 1'b0, 32'd0);
        do_access(1'b0, 32'hFFFFFFFE, 2'd3, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        do_access(1'b0, 32'hFFFFFFFF, 2'd1, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic test_random;
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a, wd;
            logic [1:0] len;
            bit wr, sx, isf;
            a   = 32'h80 + 32'($urandom_range(0, 40));
            wd  = $urandom;
            len = 2'($urandom_range(0, 3));
            wr  = 1'($urandom_range(0, 1));
            sx  = 1'($urandom_range(0, 1));
            isf = ($urandom_range(0, 3) == 0);
            if (isf) do_access(1'b1, a, 2'd3, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            else     do_access(1'b0, a, len, wr, sx, wd, 1'b0, 32'd0);
        end
    endtask

    initial begin
        // Preload RAM and shadow with the same bytes while reset is held.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            case (i)
                'h100 - 'h100: b = b;
                default: ;
            endcase
            if (i == 8'h00) b = 8'h13;
            if (i == 8'h01) b = 8'h05;
            if (i == 8'h02) b = 8'h10;
            if (i == 8'h03) b = 8'h00;
            if (i == 8'h20) b = 8'h80;
            if (i == 8'h30) b = 8'hEF;
            if (i == 8'h31) b = 8'hBE;
            ref_mem[i] = b;
            bd_we = 1'b1; bd_a = 8'(i); bd_d = b;
            @(posedge clk); #1;
        end
        bd_we = 1'b0;
        test_reset;
        test_if_fetch;
        test_loads;
        test_store;
        test_arbitration;
        test_flush;
        test_reset_mid;
        test_wrap;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
